// File: rtl/xor2_gate.sv
// Purpose: two-input XOR primitive with a registered debug side path.
// Latency: z0 is combinational (0 cycles); z0_q, z0_chg and hi_cnt update 1 cycle after the sample edge.
// Backpressure: none; the gate output is always valid and the registers sample every edge.
module xor2_gate #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x0,
  input  logic             x1,
  output logic             z0,
  output logic             z0_q,
  output logic             z0_chg,
  output logic [CNT_W-1:0] hi_cnt
);

  // Counter is held at all-ones once full so a long-high input never reads as a low count.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Gate output: pure XOR, independent of clock and reset.
  always_comb begin
    z0 = x0 ^ x1;
  end

  // Registered copy of the gate and a change strobe aligned with the new registered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z0_q   <= 1'b0;
      z0_chg <= 1'b0;
    end else begin
      z0_q   <= z0;
      z0_chg <= z0 ^ z0_q;
    end
  end

  // High-cycle counter: counts edges with z0 high, saturates, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt <= '0;
    end else if (z0 && (hi_cnt != CNT_MAX)) begin
      hi_cnt <= hi_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_xor2_gate.sv
// Purpose: scoreboard bench for xor2_gate (default width and a 2-bit counter instance).
// Latency: expected register values are queued at the drive edge and checked after the next rising edge.
// Backpressure: none; every rising edge after a drive is an output event for the monitor.
module tb_xor2_gate;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       x0;
  logic       x1;
  logic       z0_a;
  logic       z0_q_a;
  logic       z0_chg_a;
  logic [7:0] hi_cnt_a;
  logic       z0_b;
  logic       z0_q_b;
  logic       z0_chg_b;
  logic [1:0] hi_cnt_b;

  typedef struct packed {
    logic       q;
    logic       chg;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  xor2_gate #(.CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .x0(x0), .x1(x1),
    .z0(z0_a), .z0_q(z0_q_a), .z0_chg(z0_chg_a), .hi_cnt(hi_cnt_a)
  );

  xor2_gate #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .x0(x0), .x1(x1),
    .z0(z0_b), .z0_q(z0_q_b), .z0_chg(z0_chg_b), .hi_cnt(hi_cnt_b)
  );

  // Gated clock so the combinational path can be checked with clk parked low.
  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each rising edge presents new register outputs; compare against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("z0_q",      {31'd0, z0_q_a},   {31'd0, mon_e.q});
      chk("z0_chg",    {31'd0, z0_chg_a}, {31'd0, mon_e.chg});
      chk("hi_cnt",    {24'd0, hi_cnt_a}, {24'd0, mon_e.c8});
      chk("hi_cnt_w2", {30'd0, hi_cnt_b}, {30'd0, mon_e.c2});
      chk("z0_q_w2",   {31'd0, z0_q_b},   {31'd0, mon_e.q});
    end
  end

  task automatic drive(input logic a, input logic b, input logic q, input logic chg,
                       input logic [7:0] c8, input logic [1:0] c2);
    exp_t e;
    @(negedge clk);
    x0 = a;
    x1 = b;
    e.q = q; e.chg = chg; e.c8 = c8; e.c2 = c2;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic chk_regs_zero(input string nm);
    chk({nm, "_q"},   {31'd0, z0_q_a},   32'd0);
    chk({nm, "_chg"}, {31'd0, z0_chg_a}, 32'd0);
    chk({nm, "_cnt"}, {24'd0, hi_cnt_a}, 32'd0);
    chk({nm, "_cnt2"}, {30'd0, hi_cnt_b}, 32'd0);
  endtask

  task automatic do_reset();
    wait_drain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_regs_zero("seg_rst");
    x0 = 1'b0;
    x1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hard stop in case something wedges the stimulus.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tt_in [4];
    logic       tt_z  [4];
    logic [1:0] rv    [5];
    tt_in[0] = 2'b00; tt_z[0] = 1'b0;
    tt_in[1] = 2'b01; tt_z[1] = 1'b1;
    tt_in[2] = 2'b10; tt_z[2] = 1'b1;
    tt_in[3] = 2'b11; tt_z[3] = 1'b0;
    rv[0] = 2'b00; rv[1] = 2'b01; rv[2] = 2'b10; rv[3] = 2'b11; rv[4] = 2'b01;

    clk_en = 1'b0;
    rst_n  = 1'b0;
    x0     = 1'b0;
    x1     = 1'b0;
    #5;
    chk_regs_zero("por");
    rst_n = 1'b1;

    // Combinational truth table with the clock parked low.
    for (int i = 0; i < 4; i++) begin
      {x0, x1} = tt_in[i];
      #1;
      chk("z0_tt", {31'd0, z0_a}, {31'd0, tt_z[i]});
      chk("z0_tt_w2", {31'd0, z0_b}, {31'd0, tt_z[i]});
      #82;
    end

    // Reset held low while inputs and clock toggle.
    rst_n  = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {x0, x1} = rv[i];
      #1;
      chk("z0_in_rst", {31'd0, z0_a}, {31'd0, ^rv[i]});
      @(posedge clk);
      #1;
      chk_regs_zero("in_rst");
    end
    @(negedge clk);
    x0 = 1'b0;
    x1 = 1'b0;
    rst_n = 1'b1;

    // Registered path: 01 at edges 1-2, 11 at edges 3-4.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 2'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 2'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);

    // Counter: 10 for 5 edges then 11 for 3 edges.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 2'd3);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 2'd3);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 2'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 2'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 2'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 2'd3);

    // Saturation of the 2-bit counter over 6 high edges.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 2'd2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 2'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 2'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd5, 2'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 2'd3);

    // Async reset asserted between edges while hi_cnt is 4.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 2'd3);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 2'd3);
    wait_drain();
    #1;
    rst_n = 1'b0;
    #1;
    chk("clk_still_high", {31'd0, clk}, 32'd1);
    chk_regs_zero("async_rst");

    @(negedge clk);
    rst_n = 1'b1;
    clk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
